// File: rtl/dm_access_ctrl.sv
// Data-memory initiator: takes one load/store at a time, forms base+offset,
// drives the memory port, waits out the read latency and returns a response.
module dm_access_ctrl #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned TAGW   = 3,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_base,
  input  logic [AW-1:0]   req_off,
  input  logic [DW-1:0]   req_wdata,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_we,
  output logic [DW-1:0]   rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_wrap,
  output logic            dm_wflag,
  output logic [AW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_datain,
  input  logic [DW-1:0]   dm_dataout
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [TAGW-1:0] tag_q;
  logic [AW-1:0]   addr_q;
  logic            wrap_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rsp_data_q;
  logic [AW:0]     sum;

  assign sum = {1'b0, req_base} + {1'b0, req_off};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StAccess;
      StAccess: state_d = we_q ? StResp : StWait;
      StWait:   if (cnt_q == CW'(1)) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
            addr_q  <= sum[AW-1:0];
            wrap_q  <= sum[AW];
          end
        end
        StAccess: begin
          if (we_q) rsp_data_q <= '0;
          else      cnt_q      <= CW'(RD_LAT);
        end
        StWait: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) rsp_data_q <= dm_dataout;
        end
        default: ;
      endcase
    end
  end

  // Address/data registers feed the memory directly, so they hold their last
  // value between transactions; only the write strobe is gated by state.
  assign req_ready = (state_q == StIdle) & rstn;
  assign rsp_valid = (state_q == StResp);
  assign rsp_we    = we_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = tag_q;
  assign rsp_wrap  = wrap_q;
  assign dm_wflag  = (state_q == StAccess) & we_q;
  assign dm_addr   = addr_q;
  assign dm_datain = wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: driver queues expected responses,
// monitor pops and compares them, a registered memory model answers loads.
module tb_dm_access_ctrl;
  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_base = '0;
  logic [15:0] req_off = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_we;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_tag;
  logic        rsp_wrap;
  logic        dm_wflag;
  logic [15:0] dm_addr;
  logic [15:0] dm_datain;
  logic [15:0] dm_dataout = '0;

  dm_access_ctrl #(.AW(16), .DW(16), .TAGW(3), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_off(req_off), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_wrap(rsp_wrap),
    .dm_wflag(dm_wflag), .dm_addr(dm_addr), .dm_datain(dm_datain), .dm_dataout(dm_dataout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (dm_wflag) mem[dm_addr] <= dm_datain;
    dm_dataout <= mem[dm_addr];
  end

  typedef struct {
    logic        we;
    logic [15:0] data;
    logic [2:0]  tag;
    logic        wrap;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   wcount = 0;
  bit   seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) if (dm_wflag) wcount++;

  // Monitor: compare every cycle a response is presented, pop on handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      seen = 0;
    end else if (rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("rsp_latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
          seen = 1;
        end
        check("rsp_we", 32'(rsp_we), 32'(q[0].we));
        check("rsp_data", 32'(rsp_data), 32'(q[0].data));
        check("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
        check("rsp_wrap", 32'(rsp_wrap), 32'(q[0].wrap));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the ACCESS cycle.
  task automatic send(input logic we, input logic [15:0] base, input logic [15:0] off,
                      input logic [15:0] wdata, input logic [2:0] tag,
                      input logic [15:0] exp_addr, input logic exp_wrap,
                      input logic [15:0] exp_data);
    exp_t e;
    int   n;
    req_valid = 1'b1; req_we = we; req_base = base; req_off = off;
    req_wdata = wdata; req_tag = tag;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    e.we = we; e.data = exp_data; e.tag = tag; e.wrap = exp_wrap;
    e.acc = cyc; e.lat = we ? 2 : 2 + int'(RD_LAT);
    q.push_back(e);
    check("dm_addr", 32'(dm_addr), 32'(exp_addr));
    check("dm_wflag", 32'(dm_wflag), 32'(we));
    if (we) check("dm_datain", 32'(dm_datain), 32'(wdata));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0001] = 16'h1234;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_dm_wflag", 32'(dm_wflag), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);

    send(1'b1, 16'h1000, 16'h0010, 16'hBEEF, 3'd5, 16'h1010, 1'b0, 16'h0000);
    send(1'b0, 16'h1010, 16'h0000, 16'h0000, 3'd1, 16'h1010, 1'b0, 16'hBEEF);
    send(1'b0, 16'hFFFF, 16'h0002, 16'h0000, 3'd2, 16'h0001, 1'b1, 16'h1234);
    send(1'b1, 16'hFFF0, 16'h0020, 16'hA5A5, 3'd3, 16'h0010, 1'b1, 16'h0000);
    send(1'b0, 16'h0008, 16'h0008, 16'h0000, 3'd4, 16'h0010, 1'b0, 16'hA5A5);
    drain();

    // Backpressure: hold the response for 5 cycles, monitor checks stability.
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    send(1'b0, 16'h1000, 16'h0010, 16'h0000, 3'd6, 16'h1010, 1'b0, 16'hBEEF);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    repeat (5) @(negedge clk);
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_rsp_released", 32'(rsp_valid), 32'd0);
    check("bp_req_ready", 32'(req_ready), 32'd1);
    send(1'b1, 16'h2000, 16'h0004, 16'h5A5A, 3'd0, 16'h2004, 1'b0, 16'h0000);
    drain();
    check("wflag_pulses", 32'(wcount), 32'd3);

    // Reset in the WAIT state of a load aborts it.
    send(1'b0, 16'h2000, 16'h0004, 16'h0000, 3'd7, 16'h2004, 1'b0, 16'h5A5A);
    @(negedge clk);
    rstn = 1'b0;
    q.delete();
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_dm_addr", 32'(dm_addr), 32'd0);
    check("abort_rsp_tag", 32'(rsp_tag), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_no_wflag", 32'(dm_wflag), 32'd0);
    end
    check("wflag_total", 32'(wcount), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
